plot_scheduler: RTL and testbench
=================================

# plot_scheduler

Parametrised pixel-plot scheduler between the game logic and the VGA adapter. Accepts position updates from NUM_PLAYERS players over per-player valid/ack handshakes and serialises them round-robin into one x/y/colour/plot stream. Dead players are skipped, off-screen positions are filtered out, and an optional full-screen clear sweep is supported. Its output drives the vga_adapter plot port directly.

## Interface
- NUM_PLAYERS, 4, number of player channels (2..16)
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- COLOUR_W, 3, colour width
- X_MAX, 159, largest on-screen x
- Y_MAX, 119, largest on-screen y
- BG_COLOUR, 0, colour written during clear sweep
- CLOCK_50  input  1  system clock, all logic on rising edge
- resetn  input  1  synchronous active-low reset. One clock; reset is synchronous and active-low.
- pos  input  NUM_PLAYERS*(X_W+Y_W)  player i at [i*(X_W+Y_W) +: X_W+Y_W], x in upper X_W bits, y in lower Y_W bits
- pos_valid  input  NUM_PLAYERS  player i has a new position to plot
- pos_ack  output  NUM_PLAYERS  one-hot, one-cycle pulse: player i's position captured this cycle
- alive  input  NUM_PLAYERS  0 = player ignored (never acked, never plotted)
- colour_tbl  input  NUM_PLAYERS*COLOUR_W  player i colour at [i*COLOUR_W +: COLOUR_W]
- clear_req  input  1  request full-screen clear (level, sampled in NORMAL)
- busy  output  1  high while in CLEAR
- x  output  X_W  plot x
- y  output  Y_W  plot y
- colour  output  COLOUR_W  plot colour
- plot  output  1  write enable to VGA adapter, one cycle per pixel

## Operation
- States: NORMAL, CLEAR. Reset → NORMAL.
- Round-robin pointer ptr (width clog2(NUM_PLAYERS)), reset 0.
- NORMAL, each cycle: eligible = pos_valid & alive. Search starts at ptr, ascending with wrap (ptr, ptr+1, …, NUM_PLAYERS-1, 0, …). First eligible i is granted:
  - pos_ack[i] = 1 combinationally in the grant cycle; all other bits 0.
  - On the edge: x/y ← pos slice i, colour ← colour_tbl slice i, ptr ← (i+1) mod NUM_PLAYERS.
  - plot ← 1 if x ≤ X_MAX and y ≤ Y_MAX, else 0. Off-screen positions are still acked, then dropped.
- No eligible player: pos_ack = 0, plot ← 0, ptr unchanged, x/y/colour hold.
- A player holding pos_valid high continuously is acked at most once per NUM_PLAYERS cycles when all players are eligible. The ack is the consume point, and the producer updates pos the following cycle.
- Transitions: NORMAL→CLEAR when clear_req=1 (macro enabled). Clear has priority over a grant in the same cycle: no ack is issued and ptr is unchanged. CLEAR→NORMAL on the edge after pixel (X_MAX, Y_MAX) is issued.
- CLEAR: counters cx and cy reset to 0 on entry. Each cycle: x←cx, y←cy, colour←BG_COLOUR, plot←1. cx increments and wraps X_MAX→0 with cy incrementing. pos_ack held 0, busy=1. clear_req is ignored while in CLEAR.
- Reset (resetn=0 at an edge) in any state, including mid-sweep: state=NORMAL, ptr=0, cx=cy=0. Outputs reset: x=0, y=0, colour=0, plot=0, busy=0. pos_ack=0 while resetn=0.

## Timing
- Grant-to-plot latency: 1 cycle. pos_ack is high in cycle k and plot/x/y/colour are valid in cycle k+1.
- Throughput: 1 pixel/cycle in both states.
- Clear sweep: exactly (X_MAX+1)*(Y_MAX+1) plot cycles (19200 at defaults). busy rises in the first sweep cycle and falls the cycle after the last one. The first NORMAL grant is possible in the cycle busy is low.
- Outputs are registered. pos_ack is combinational from ptr, state, pos_valid and alive only, with no path from pos.

## Configuration
- CLEAR_SWEEP_EN defined: CLEAR state, cx/cy counters and busy are implemented as above.
- Not defined: clear_req is ignored, busy is tied 0, and the block is NORMAL only. Grant behaviour is identical.

## Test plan
- Reset, then pos_valid=4'b1111, alive=4'b1111, positions p0=(10,5), p1=(20,6), p2=(30,7), p3=(40,8) held constant → acks 0001,0010,0100,1000 repeating; plot=1 every cycle one cycle after each ack with the matching x/y/colour.
- alive=4'b1011, all valid → acks cycle 0,1,3 only; player 2 is never acked or plotted.
- p1=(160,5), valid only on p1 → pos_ack[1] pulses and plot stays 0.
- ptr=2 (after granting player 1), valid=4'b0011 → player 0 granted first, then player 1.
- With CLEAR_SWEEP_EN: clear_req=1 together with pos_valid=4'b0001 → no ack; 19200 plots with BG_COLOUR; first pixel (0,0), last pixel (159,119); busy high for exactly 19200 cycles; player 0 is acked in the cycle busy falls.
- Reset asserted at sweep pixel 500 → next cycle plot=0, busy=0, x=y=0, state NORMAL.

Source files
------------

// File: rtl/plot_scheduler.sv
// plot_scheduler: round-robin pixel-plot scheduler feeding the vga_adapter plot port.
// Player position updates arrive on per-player valid/ack handshakes. They are
// serialised into a single registered x/y/colour/plot stream. Dead players are
// skipped and off-screen positions are dropped after being acked.
// Optional feature macro: CLEAR_SWEEP_EN enables the full-screen clear sweep
// (CLEAR state, cx/cy counters, busy). When it is undefined, clear_req is
// ignored and busy is tied low.
//
// state  | meaning
// -------+-------------------------------------------------------------
// NORMAL | round-robin grant of eligible players, one pixel per grant
// CLEAR  | raster sweep of BG_COLOUR over every on-screen pixel
module plot_scheduler #(
  parameter int NUM_PLAYERS = 4,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int COLOUR_W    = 3,
  parameter int X_MAX       = 159,
  parameter int Y_MAX       = 119,
  parameter int BG_COLOUR   = 0
) (
  input  logic                              CLOCK_50,
  input  logic                              resetn,
  input  logic [NUM_PLAYERS*(X_W+Y_W)-1:0]  pos,
  input  logic [NUM_PLAYERS-1:0]            pos_valid,
  output logic [NUM_PLAYERS-1:0]            pos_ack,
  input  logic [NUM_PLAYERS-1:0]            alive,
  input  logic [NUM_PLAYERS*COLOUR_W-1:0]   colour_tbl,
  input  logic                              clear_req,
  output logic                              busy,
  output logic [X_W-1:0]                    x,
  output logic [Y_W-1:0]                    y,
  output logic [COLOUR_W-1:0]               colour,
  output logic                              plot
);

  localparam int PW    = X_W + Y_W;
  localparam int PTR_W = $clog2(NUM_PLAYERS);

  typedef enum logic {ST_NORMAL = 1'b0, ST_CLEAR = 1'b1} state_t;

  state_t                state_q;
  logic [PTR_W-1:0]      ptr_q;
  logic [PTR_W-1:0]      ptr_d;
  logic [X_W-1:0]        x_q;
  logic [Y_W-1:0]        y_q;
  logic [COLOUR_W-1:0]   colour_q;
  logic                  plot_q;

  logic [NUM_PLAYERS-1:0] eligible;
  logic                   clear_go;
  logic                   grant_en;
  logic                   gnt_found;
  logic [PTR_W-1:0]       gnt_idx;
  logic [PTR_W:0]         cand;
  logic [PW-1:0]          sel_pos;
  logic [COLOUR_W-1:0]    sel_col;
  logic [X_W-1:0]         sel_x;
  logic [Y_W-1:0]         sel_y;
  logic                   on_screen;

`ifdef CLEAR_SWEEP_EN
  logic [X_W-1:0]         cx_q;
  logic [Y_W-1:0]         cy_q;
  logic                   busy_q;
  logic                   sweep_last;

  assign clear_go   = (state_q == ST_NORMAL) && clear_req;
  assign sweep_last = (cx_q == X_W'(X_MAX)) && (cy_q == Y_W'(Y_MAX));
  assign busy       = busy_q;
`else
  logic unused_clear_req;

  assign unused_clear_req = clear_req;
  assign clear_go         = 1'b0;
  assign busy             = 1'b0;
`endif

  assign eligible = pos_valid & alive;
  // A pending clear pre-empts any grant in the same cycle.
  assign grant_en = resetn && (state_q == ST_NORMAL) && !clear_go;

  // Round-robin search: first eligible player at or after ptr, with wrap.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_PLAYERS; k++) begin
      cand = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_PLAYERS)) begin
        cand = cand - (PTR_W+1)'(NUM_PLAYERS);
      end
      if (!gnt_found && eligible[cand[PTR_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // Mux the granted player's position and colour. The ack path never sees pos.
  always_comb begin
    sel_pos = '0;
    sel_col = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (gnt_idx == PTR_W'(i)) begin
        sel_pos = pos[i*PW +: PW];
        sel_col = colour_tbl[i*COLOUR_W +: COLOUR_W];
      end
    end
  end

  assign sel_x     = sel_pos[PW-1 -: X_W];
  assign sel_y     = sel_pos[Y_W-1:0];
  assign on_screen = ({1'b0, sel_x} <= (X_W+1)'(X_MAX)) &&
                     ({1'b0, sel_y} <= (Y_W+1)'(Y_MAX));
  assign ptr_d     = (gnt_idx == PTR_W'(NUM_PLAYERS-1)) ? '0 : gnt_idx + PTR_W'(1);
  assign pos_ack   = (grant_en && gnt_found) ? (NUM_PLAYERS'(1) << gnt_idx) : '0;

  // Scheduler FSM with registered plot outputs.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q  <= ST_NORMAL;
      ptr_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
`ifdef CLEAR_SWEEP_EN
      cx_q     <= '0;
      cy_q     <= '0;
      busy_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_NORMAL: begin
`ifdef CLEAR_SWEEP_EN
          if (clear_req) begin
            state_q <= ST_CLEAR;
            busy_q  <= 1'b1;
            cx_q    <= '0;
            cy_q    <= '0;
            plot_q  <= 1'b0;
          end else
`endif
          if (gnt_found) begin
            x_q      <= sel_x;
            y_q      <= sel_y;
            colour_q <= sel_col;
            plot_q   <= on_screen;
            ptr_q    <= ptr_d;
          end else begin
            plot_q   <= 1'b0;
          end
        end
`ifdef CLEAR_SWEEP_EN
        ST_CLEAR: begin
          x_q      <= cx_q;
          y_q      <= cy_q;
          colour_q <= COLOUR_W'(BG_COLOUR);
          plot_q   <= 1'b1;
          if (sweep_last) begin
            state_q <= ST_NORMAL;
            busy_q  <= 1'b0;
            cx_q    <= '0;
            cy_q    <= '0;
          end else if (cx_q == X_W'(X_MAX)) begin
            cx_q <= '0;
            cy_q <= cy_q + Y_W'(1);
          end else begin
            cx_q <= cx_q + X_W'(1);
          end
        end
`endif
        default: begin
          state_q <= ST_NORMAL;
          plot_q  <= 1'b0;
        end
      endcase
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;

endmodule

// File: tb/tb_plot_scheduler.sv
// Self-checking bench for plot_scheduler (default parameters).
// The reference model tracks only the round-robin pointer and the expected
// plot outputs. Expected grants come straight from the priority rule.
module tb_plot_scheduler;
  localparam int N = 4, XW = 8, YW = 7, CW = 3, XMAX = 159, YMAX = 119, BG = 0;
`ifdef CLEAR_SWEEP_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic                  CLOCK_50 = 1'b0;
  logic                  resetn   = 1'b0;
  logic [N*(XW+YW)-1:0]  pos      = '0;
  logic [N-1:0]          pos_valid = '0;
  logic [N-1:0]          pos_ack;
  logic [N-1:0]          alive    = '0;
  logic [N*CW-1:0]       colour_tbl = '0;
  logic                  clear_req = 1'b0;
  logic                  busy;
  logic [XW-1:0]         x;
  logic [YW-1:0]         y;
  logic [CW-1:0]         colour;
  logic                  plot;

  plot_scheduler dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .pos(pos), .pos_valid(pos_valid),
    .pos_ack(pos_ack), .alive(alive), .colour_tbl(colour_tbl),
    .clear_req(clear_req), .busy(busy), .x(x), .y(y), .colour(colour), .plot(plot)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int tests = 0, fails = 0;
  int m_ptr = 0, e_x = 0, e_y = 0, e_c = 0;
  bit e_plot = 1'b0;
  int px[N], py[N], pc[N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pack();
    int xi, yi, ci;
    for (int i = 0; i < N; i++) begin
      xi = px[i]; yi = py[i]; ci = pc[i];
      pos[i*(XW+YW) +: XW+YW] = {xi[XW-1:0], yi[YW-1:0]};
      colour_tbl[i*CW +: CW]  = ci[CW-1:0];
    end
  endtask

  function automatic int m_grant();
    int i;
    if (CLR_EN && clear_req) return -1;
    for (int k = 0; k < N; k++) begin
      i = (m_ptr + k) % N;
      if (pos_valid[i] && alive[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_edge(input int g);
    if (g >= 0) begin
      e_x = px[g]; e_y = py[g]; e_c = pc[g];
      e_plot = (px[g] <= XMAX) && (py[g] <= YMAX);
      m_ptr = (g + 1) % N;
    end else begin
      e_plot = 1'b0;
    end
  endtask

  // One NORMAL-mode cycle: check at negedge, advance the model at posedge.
  task automatic cyc(input int want_ack = -1);
    int g;
    @(negedge CLOCK_50);
    g = m_grant();
    check("ack", 32'(pos_ack), (g < 0) ? 32'd0 : 32'(1 << g));
    if (want_ack >= 0) check("ack_const", 32'(pos_ack), 32'(want_ack));
    check("plot", 32'(plot), 32'(e_plot));
    check("x", 32'(x), 32'(e_x));
    check("y", 32'(y), 32'(e_y));
    check("colour", 32'(colour), 32'(e_c));
    check("busy", 32'(busy), 32'd0);
    @(posedge CLOCK_50);
    model_edge(g);
    #1;
  endtask

  task automatic set_pos(input int i, input int xv, input int yv, input int cv);
    px[i] = xv; py[i] = yv; pc[i] = cv;
  endtask

  initial begin
    int pat2[3];
    int nb, np, bad;
    bit done;
    pat2[0] = 1; pat2[1] = 2; pat2[2] = 8;

    // Reset: outputs cleared, no ack while resetn is low.
    set_pos(0, 10, 5, 1); set_pos(1, 20, 6, 2); set_pos(2, 30, 7, 3); set_pos(3, 40, 8, 4);
    pack();
    pos_valid = 4'b1111; alive = 4'b1111;
    @(posedge CLOCK_50); @(negedge CLOCK_50);
    check("rst_ack", 32'(pos_ack), 32'd0);
    check("rst_plot", 32'(plot), 32'd0);
    check("rst_x", 32'(x), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_colour", 32'(colour), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge CLOCK_50); #1;
    resetn = 1'b1;

    // All players valid and alive: strict rotation.
    for (int c = 0; c < 12; c++) cyc(1 << (c % 4));

    // Player 2 dead: rotation over 0,1,3.
    alive = 4'b1011;
    for (int c = 0; c < 9; c++) cyc(pat2[c % 3]);

    // Off-screen x: still acked, never plotted.
    alive = 4'b1111; pos_valid = 4'b0010;
    set_pos(1, 160, 5, 2); pack();
    cyc(2);
    cyc(2);
    set_pos(1, 20, 120, 2); pack();
    cyc(2);

    // ptr=2 after granting player 1; player 0 wins first, then player 1.
    set_pos(1, 20, 6, 2); pack();
    pos_valid = 4'b0011;
    cyc(1);
    cyc(2);
    cyc(1);

`ifdef CLEAR_SWEEP_EN
    // Full sweep, clear taking priority over a same-cycle grant.
    clear_req = 1'b1; pos_valid = 4'b0001;
    @(negedge CLOCK_50);
    check("clr_noack", 32'(pos_ack), 32'd0);
    @(posedge CLOCK_50); #1;
    clear_req = 1'b0;
    nb = 0; np = 0; bad = 0; done = 1'b0;
    for (int c = 0; c < 19400 && !done; c++) begin
      @(negedge CLOCK_50);
      if (busy) nb++;
      if (plot) begin
        if (x !== XW'(np % 160) || y !== YW'(np / 160) || colour !== CW'(BG)) bad++;
        if (np == 0) begin
          check("clr_first_x", 32'(x), 32'd0);
          check("clr_first_y", 32'(y), 32'd0);
        end
        np++;
      end
      if (pos_ack !== '0 && busy) bad++;
      if (!busy) begin
        done = 1'b1;
        check("clr_ack_on_fall", 32'(pos_ack), 32'd1);
        check("clr_last_x", 32'(x), 32'(XMAX));
        check("clr_last_y", 32'(y), 32'(YMAX));
      end
    end
    check("clr_done", 32'(done), 32'd1);
    check("clr_busy_cycles", 32'(nb), 32'd19200);
    check("clr_plots", 32'(np), 32'd19200);
    check("clr_bad_pixels", 32'(bad), 32'd0);
    @(posedge CLOCK_50);
    model_edge(m_grant());
    #1;
    cyc(1);

    // Reset in the middle of a sweep.
    pos_valid = 4'b0000;
    clear_req = 1'b1;
    @(posedge CLOCK_50); #1;
    clear_req = 1'b0;
    np = 0; done = 1'b0;
    for (int c = 0; c < 700 && !done; c++) begin
      @(negedge CLOCK_50);
      if (plot) np++;
      if (np == 500) done = 1'b1;
    end
    check("mid_reached", 32'(done), 32'd1);
    check("mid_busy", 32'(busy), 32'd1);
    resetn = 1'b0; pos_valid = 4'b0001;
    #1;
    check("mid_rst_ack", 32'(pos_ack), 32'd0);
    @(posedge CLOCK_50); #1;
    check("mid_plot", 32'(plot), 32'd0);
    check("mid_busy_low", 32'(busy), 32'd0);
    check("mid_x", 32'(x), 32'd0);
    check("mid_y", 32'(y), 32'd0);
    resetn = 1'b1;
    m_ptr = 0; e_x = 0; e_y = 0; e_c = 0; e_plot = 1'b0;
    pos_valid = 4'b0010;
    cyc(2);
    cyc(2);
`else
    // Without the sweep, clear_req has no effect on grants.
    clear_req = 1'b1; pos_valid = 4'b0001;
    cyc(1);
    cyc(1);
    clear_req = 1'b0;
`endif

    // Randomised traffic, including off-screen and dead players.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) set_pos(i, $urandom_range(175), $urandom_range(127), $urandom_range(7));
      pack();
      pos_valid = N'($urandom);
      alive     = N'($urandom) | N'($urandom);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
